// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolation chain: sequencer states and
// default stage geometry used by the sequencer and the filter stage modules.
package cic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } cic_state_e;

  localparam int CIC_BITWIDTH   = 32;
  localparam int CIC_NUM_STAGES = 4;

endpackage

// File: rtl/cic_phase_counter.sv
// Interpolation-factor latch and 0..R-1 phase counter with hold, exposing
// phase-0 and last-phase (wrap) flags to the sequencer.
module cic_phase_counter #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              hold,
  output logic              phase0,
  output logic              wrap
);

  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] phase_q, phase_d;

  assign phase0 = (phase_q == '0);
  assign wrap   = (phase_q == rate_q - RATE_W'(1));

  always_comb begin
    rate_d  = rate_q;
    phase_d = phase_q;
    if (load) begin
      // cfg_rate of 0 is treated as R=1
      rate_d  = (cfg_rate == '0) ? RATE_W'(1) : cfg_rate;
      phase_d = '0;
    end else if (!hold) begin
      phase_d = wrap ? '0 : phase_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_q  <= RATE_W'(1);
      phase_q <= '0;
    end else begin
      rate_q  <= rate_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/cic_interp_sequencer.sv
// CIC interpolator sequencer: zero-stuffs low-rate samples by R, drives the
// comb/integrator enables, chain clear and output strobe, and drains on stop.
module cic_interp_sequencer
  import cic_pkg::*;
#(
  parameter int BITWIDTH   = CIC_BITWIDTH,
  parameter int NUM_STAGES = CIC_NUM_STAGES,
  parameter int RATE_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RATE_W-1:0]   cfg_rate,
  input  logic                start,
  input  logic                stop,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BITWIDTH-1:0] comb_in,
  output logic                comb_ena,
  output logic                int_ena,
  output logic                stuff_sel,
  output logic                chain_clr,
  output logic                out_valid,
  output logic                busy,
  output logic                underrun,
  output logic                done
);

  localparam int DRAIN_W = $clog2(NUM_STAGES + 1);

  cic_state_e          state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [BITWIDTH-1:0] comb_in_q, comb_in_d;
  logic comb_ena_q, comb_ena_d, int_ena_q, int_ena_d, stuff_sel_q, stuff_sel_d;
  logic chain_clr_q, chain_clr_d, out_valid_q, out_valid_d;
  logic underrun_q, underrun_d, done_q, done_d, stop_pend_q, stop_pend_d;
  logic load, hold, phase0, wrap;

  cic_phase_counter #(.RATE_W(RATE_W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .cfg_rate (cfg_rate),
    .hold     (hold),
    .phase0   (phase0),
    .wrap     (wrap)
  );

  // A pending stop blocks the next accept so drain starts at that phase 0.
  assign in_ready = (state_q == S_RUN) && phase0 && !stop_pend_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    comb_in_d   = comb_in_q;
    comb_ena_d  = 1'b0;
    int_ena_d   = 1'b0;
    stuff_sel_d = 1'b0;
    chain_clr_d = 1'b0;
    out_valid_d = int_ena_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    load        = 1'b0;
    hold        = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLR;
          load        = 1'b1;
          chain_clr_d = 1'b1;
          underrun_d  = 1'b0;
          stop_pend_d = 1'b0;
          drain_d     = '0;
        end
      end
      S_CLR: state_d = S_RUN;
      S_RUN: begin
        if (phase0) begin
          if (in_ready && in_valid) begin
            comb_in_d   = in_data;
            comb_ena_d  = 1'b1;
            stuff_sel_d = 1'b1;
            int_ena_d   = 1'b1;
            hold        = 1'b0;
            if (stop) stop_pend_d = 1'b1;
          end else if (stop || stop_pend_q) begin
            state_d     = S_DRAIN;
            stop_pend_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          int_ena_d = 1'b1;
          hold      = 1'b0;
          if (stop) stop_pend_d = 1'b1;
        end
      end
      S_DRAIN: begin
        int_ena_d = 1'b1;
        hold      = 1'b0;
        if (phase0) begin
          comb_in_d   = '0;
          comb_ena_d  = 1'b1;
          stuff_sel_d = 1'b1;
        end
        if (wrap) begin
          if (drain_q == DRAIN_W'(NUM_STAGES - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            drain_d = '0;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      comb_in_q   <= '0;
      comb_ena_q  <= 1'b0;
      int_ena_q   <= 1'b0;
      stuff_sel_q <= 1'b0;
      chain_clr_q <= 1'b0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      comb_in_q   <= comb_in_d;
      comb_ena_q  <= comb_ena_d;
      int_ena_q   <= int_ena_d;
      stuff_sel_q <= stuff_sel_d;
      chain_clr_q <= chain_clr_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign comb_in   = comb_in_q;
  assign comb_ena  = comb_ena_q;
  assign int_ena   = int_ena_q;
  assign stuff_sel = stuff_sel_q;
  assign chain_clr = chain_clr_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign underrun  = underrun_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cic_interp_sequencer.sv
// Directed bench for cic_interp_sequencer with hand-computed expectations.
module tb_cic_interp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_rate;
  logic        start, stop, in_valid;
  logic [31:0] in_data;
  logic        in_ready, comb_ena, int_ena, stuff_sel, chain_clr;
  logic        out_valid, busy, underrun, done;
  logic [31:0] comb_in;

  int n_vec  = 0;
  int n_miss = 0;
  int n;

  cic_interp_sequencer #(.BITWIDTH(32), .NUM_STAGES(4), .RATE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_rate  (cfg_rate),
    .start     (start),
    .stop      (stop),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comb_in   (comb_in),
    .comb_ena  (comb_ena),
    .int_ena   (int_ena),
    .stuff_sel (stuff_sel),
    .chain_clr (chain_clr),
    .out_valid (out_valid),
    .busy      (busy),
    .underrun  (underrun),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".comb_in"}, comb_in, 32'd0);
    chk({tag, ".ena"}, {31'd0, comb_ena | int_ena | stuff_sel}, 32'd0);
    chk({tag, ".clr_ov"}, {31'd0, chain_clr | out_valid}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".underrun"}, {31'd0, underrun}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done(input int bound, output int cnt);
    cnt = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (done) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic run_r1(input logic [7:0] cfg);
    cfg_rate = cfg; start = 1'b1;
    step(); start = 1'b0;
    step();
    chk("r1.ready0", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h10 * cfg + i + 32'h10;
      step();
      chk("r1.comb_in", comb_in, 32'h10 * cfg + i + 32'h10);
      chk("r1.ena", {29'd0, comb_ena, stuff_sel, int_ena}, 32'd7);
      chk("r1.ready", {31'd0, in_ready}, 32'd1);
    end
    in_data = 32'hEE; stop = 1'b1;
    step(); stop = 1'b0; in_valid = 1'b0;
    chk("r1.last", comb_in, 32'hEE);
    chk("r1.ready_pend", {31'd0, in_ready}, 32'd0);
    step();
    chk("r1.bubble", {31'd0, int_ena}, 32'd0);
    wait_done(64, n);
    chk("r1.drain_len", n, 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_rate = '0;
    in_data = '0; in_valid = 1'b0;
    #3;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b1;
    step();
    chk("idle.busy", {31'd0, busy}, 32'd0);

    // R=4, in_valid held high, start/cfg_rate poked mid-run
    cfg_rate = 8'd4; start = 1'b1; in_valid = 1'b1; in_data = 32'd1;
    step(); start = 1'b0;
    chk("r4.clr", {31'd0, chain_clr}, 32'd1);
    chk("r4.busy", {31'd0, busy}, 32'd1);
    chk("r4.ready_clr", {31'd0, in_ready}, 32'd0);
    step();
    chk("r4.clr_off", {31'd0, chain_clr}, 32'd0);
    chk("r4.ready_first", {31'd0, in_ready}, 32'd1);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 5) begin start = 1'b1; cfg_rate = 8'd7; end
      if (cyc == 6) start = 1'b0;
      step();
      chk("r4.comb_ena", {31'd0, comb_ena}, {31'd0, cyc % 4 == 0});
      chk("r4.stuff", {31'd0, stuff_sel}, {31'd0, cyc % 4 == 0});
      chk("r4.int_ena", {31'd0, int_ena}, 32'd1);
      chk("r4.comb_in", comb_in, cyc / 4 + 1);
      chk("r4.ready", {31'd0, in_ready}, {31'd0, cyc % 4 == 3});
      chk("r4.out_valid", {31'd0, out_valid}, {31'd0, cyc != 0});
      in_data = (cyc + 1) / 4 + 1;
    end
    stop = 1'b1;
    step(); stop = 1'b0; in_valid = 1'b0;
    chk("r4.stop_acc", comb_in, 32'd4);
    chk("r4.stop_ena", {31'd0, comb_ena}, 32'd1);
    step(); step(); step();
    chk("r4.pend_ready", {31'd0, in_ready}, 32'd0);
    chk("r4.pend_int", {31'd0, int_ena}, 32'd1);
    step();
    chk("r4.bubble", {30'd0, int_ena, comb_ena}, 32'd0);
    chk("r4.bubble_busy", {31'd0, busy}, 32'd1);
    wait_done(64, n);
    chk("r4.drain_len", n, 32'd16);
    chk("r4.done_busy", {31'd0, busy}, 32'd0);
    chk("r4.done_int", {31'd0, int_ena}, 32'd1);
    step();
    chk("r4.done_pulse", {31'd0, done}, 32'd0);
    chk("r4.ov_tail", {31'd0, out_valid}, 32'd1);

    run_r1(8'd0);
    run_r1(8'd1);

    // R=3 with a 5-cycle source stall, then stop during a phase-0 stall
    cfg_rate = 8'd3; start = 1'b1;
    step(); start = 1'b0;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r3.stall_ena", {30'd0, int_ena, comb_ena}, 32'd0);
      chk("r3.stall_ready", {31'd0, in_ready}, 32'd1);
      chk("r3.underrun", {31'd0, underrun}, 32'd1);
    end
    in_valid = 1'b1; in_data = 32'h55;
    step(); in_valid = 1'b0;
    chk("r3.acc", comb_in, 32'h55);
    chk("r3.acc_ena", {30'd0, comb_ena, int_ena}, 32'd3);
    chk("r3.acc_ready", {31'd0, in_ready}, 32'd0);
    step(); step();
    chk("r3.wrap_ready", {31'd0, in_ready}, 32'd1);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("r3.stop_stall", {31'd0, int_ena}, 32'd0);
    wait_done(64, n);
    chk("r3.drain_len", n, 32'd12);
    chk("r3.underrun_sticky", {31'd0, underrun}, 32'd1);

    // R=2, stop during phase 1 completes the period, then 8-cycle drain
    cfg_rate = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    chk("r2.underrun_clr", {31'd0, underrun}, 32'd0);
    step(); in_valid = 1'b1; in_data = 32'd7;
    step(); in_valid = 1'b0;
    chk("r2.acc", comb_in, 32'd7);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("r2.ph1", {29'd0, int_ena, comb_ena, in_ready}, 32'd4);
    step();
    chk("r2.bubble", {31'd0, int_ena}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("r2.d_comb_in", comb_in, 32'd0);
      chk("r2.d_comb_ena", {31'd0, comb_ena}, {31'd0, i % 2 == 0});
      chk("r2.d_stuff", {31'd0, stuff_sel}, {31'd0, i % 2 == 0});
      chk("r2.d_int", {31'd0, int_ena}, 32'd1);
      chk("r2.d_ready", {31'd0, in_ready}, 32'd0);
      chk("r2.d_done", {31'd0, done}, {31'd0, i == 7});
      chk("r2.d_busy", {31'd0, busy}, {31'd0, i != 7});
    end
    step();
    chk("r2.post", {30'd0, done, busy}, 32'd0);

    // asynchronous reset in the middle of a drain
    cfg_rate = 8'd2; start = 1'b1;
    step(); start = 1'b0;
    step(); stop = 1'b1;
    step(); stop = 1'b0;
    step(); step(); step();
    chk("rst.pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("rst.async");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst.idle", {28'd0, busy, done, in_ready, comb_ena}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
